// File: rtl/overlap_pkg.sv
// Shared definitions for the IMDCT overlap-add storage: default sizes, FSM
// encodings of the read side and a width-generic saturating adder.
package overlap_pkg;

    localparam int unsigned HALF_WINDOW_SIZE_DEFAULT = 512;
    localparam int unsigned WORD_LENGTH_DEFAULT      = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_ACCEPT = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    // Operands arrive sign-extended to 64 bits; the caller narrows the result
    // back to `width`, which is safe because the clamp keeps it in range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/overlap_reader.sv
// Read side of the overlap-add stage: fetches the previous frame's stored
// half-window and adds it, saturated, to the current frame's first half.
module overlap_reader
    import overlap_pkg::*;
#(
    parameter int unsigned halfWindowSize = HALF_WINDOW_SIZE_DEFAULT,
    parameter int unsigned wordLength     = WORD_LENGTH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_rd_en,
    output logic [$clog2(halfWindowSize)-1:0] mem_addr,
    input  logic [wordLength-1:0]             mem_data,
    input  logic                              in_valid,
    input  logic [wordLength-1:0]             in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [wordLength-1:0]             out_data,
    input  logic                              out_ready
);

    localparam int unsigned   AW       = $clog2(halfWindowSize);
    localparam logic [AW-1:0] LAST_IDX = AW'(halfWindowSize - 1);

    logic [2:0]            state;
    logic [AW-1:0]         idx;
    logic [wordLength-1:0] prev;
    logic [wordLength-1:0] sum;
    logic                  primed;
    logic                  done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            prev   <= '0;
            sum    <= '0;
            primed <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    // Nothing was stored before the first frame, so overlap with zero.
                    prev  <= primed ? mem_data : '0;
                    state <= ST_ACCEPT;
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        sum   <= wordLength'(sat_add(64'(signed'(prev)),
                                                     64'(signed'(in_data)),
                                                     wordLength));
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            done_r <= 1'b1;
                            primed <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // idx is only written on start and on advance, so the address holds
    // its last value outside FETCH without a separate register.
    assign mem_addr  = idx;
    assign mem_rd_en = (state == ST_FETCH);
    assign in_ready  = (state == ST_ACCEPT);
    assign out_valid = (state == ST_OUT);
    assign out_data  = sum;
    assign busy      = (state != ST_IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_overlap_reader.sv
// Directed self-checking bench for overlap_reader with a behavioural
// synchronous-read overlap memory.
module tb_overlap_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [8:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;

    logic [15:0] mem [512];
    int n_checks = 0;
    int n_fail   = 0;
    int overlap_cycles = 0;
    int done_cnt = 0;

    overlap_reader #(.halfWindowSize(512), .wordLength(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem[mem_addr];
        if (in_ready && out_valid) overlap_cycles++;
        if (done) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drives one sample through FETCH/LATCH/ACCEPT/OUT starting from the
    // FETCH cycle; reports what was observed, the caller judges it.
    task automatic xfer(input logic [15:0] d, input int gap, input int hold,
                        input bit pulse, output logic [15:0] got, output int rd,
                        output logic [8:0] addr, output int lat,
                        output int hold_bad, output bit timeout);
        got = '0; rd = 0; addr = '0; lat = 0; hold_bad = 0; timeout = 1'b0;
        while (!in_ready) begin
            if (mem_rd_en) begin
                rd++;
                addr = mem_addr;
            end
            if (lat >= 40) begin
                timeout = 1'b1;
                return;
            end
            @(negedge clk);
            lat++;
        end
        repeat (gap) begin
            if (!in_ready || out_valid) hold_bad++;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        if (pulse) start = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 16'($urandom);
        if (!out_valid) begin
            timeout = 1'b1;
            return;
        end
        got = out_data;
        repeat (hold) begin
            if (!out_valid || out_data !== got || mem_rd_en || in_ready) hold_bad++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
        if (mem_addr !== 9'd0)  begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic [15:0] got; logic [8:0] addr; int rd, lat, hb; bit to;
        for (int i = 0; i < 512; i++) mem[i] = 16'h7FFF;
        pulse_start();
        n_checks += 3;
        if (busy !== 1'b1)      begin n_fail++; $display("FAIL start_busy got %b want 1", busy); end
        if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL start_rd_en got %b want 1", mem_rd_en); end
        if (mem_addr !== 9'd0)  begin n_fail++; $display("FAIL start_addr got %0d want 0", mem_addr); end
        for (int i = 0; i < 512; i++) begin
            xfer(16'(i), 0, 0, 1'b0, got, rd, addr, lat, hb, to);
            n_checks += 2;
            if (to) begin n_fail++; $display("FAIL pass_timeout at i=%0d", i); end
            if (got !== 16'(i)) begin n_fail++; $display("FAIL pass_data i=%0d got %h want %h", i, got, 16'(i)); end
            if (i == 0) begin
                n_checks++;
                if (lat != 2) begin n_fail++; $display("FAIL first_latency got %0d want 2", lat); end
            end
            if (i == 510) begin
                n_checks++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL early_done got %b want 0", done); end
            end
        end
        n_checks += 2;
        if (done !== 1'b1) begin n_fail++; $display("FAIL pass_done got %b want 1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pass_busy_end got %b want 0", busy); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", done); end
    endtask

    task automatic test_overlap();
        logic [15:0] got; logic [8:0] addr; int rd, lat, hb; bit to;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            xfer(16'(2 * i), 0, 0, 1'b0, got, rd, addr, lat, hb, to);
            n_checks += 3;
            if (got !== 16'(3 * i)) begin n_fail++; $display("FAIL overlap_data i=%0d got %h want %h", i, got, 16'(3 * i)); end
            if (addr !== 9'(i))     begin n_fail++; $display("FAIL overlap_addr i=%0d got %0d want %0d", i, addr, i); end
            if (rd != 1 || to)      begin n_fail++; $display("FAIL overlap_rd_count i=%0d got %0d want 1", i, rd); end
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL overlap_done got %b want 1", done); end
    endtask

    task automatic test_saturation_backpressure();
        logic [15:0] got, want; logic [8:0] addr; int rd, lat, hb; bit to;
        logic [15:0] m_tab [7] = '{16'h7000, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 16'h0010, 16'h7FFF};
        logic [15:0] d_tab [7] = '{16'h7000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h0005, 16'h8000};
        logic [15:0] e_tab [7] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0015, 16'hFFFF};
        for (int i = 0; i < 512; i++) mem[i] = (i < 7) ? m_tab[i] : 16'h0010;
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            want = (i < 7) ? e_tab[i] : 16'(i + 16);
            xfer((i < 7) ? d_tab[i] : 16'(i), 0, (i == 5) ? 10 : 0, 1'b0,
                 got, rd, addr, lat, hb, to);
            n_checks++;
            if (got !== want || to) begin n_fail++; $display("FAIL sat_data i=%0d got %h want %h", i, got, want); end
            if (i == 5) begin
                n_checks += 2;
                if (hb != 0) begin n_fail++; $display("FAIL backpressure_hold got %0d bad cycles want 0", hb); end
                if (mem_addr !== 9'd6 || mem_rd_en !== 1'b1) begin
                    n_fail++; $display("FAIL backpressure_next_fetch got addr %0d rd %b want 6 1", mem_addr, mem_rd_en);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL sat_done got %b want 1", done); end
    endtask

    task automatic test_gaps_start();
        logic [15:0] got; logic [8:0] addr; int rd, lat, hb; bit to;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            xfer(16'h0100, int'($urandom_range(0, 3)), 0, (i == 100), got, rd, addr, lat, hb, to);
            n_checks += 3;
            if (got !== 16'(i + 256) || to) begin n_fail++; $display("FAIL gap_data i=%0d got %h want %h", i, got, 16'(i + 256)); end
            if (addr !== 9'(i) || rd != 1)  begin n_fail++; $display("FAIL gap_addr i=%0d got %0d want %0d", i, addr, i); end
            if (hb != 0)                    begin n_fail++; $display("FAIL gap_in_ready i=%0d got %0d bad cycles want 0", i, hb); end
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b want 1", done); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] got; logic [8:0] addr; int rd, lat, hb, done_before; bit to;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            xfer(16'(i), 0, 0, 1'b0, got, rd, addr, lat, hb, to);
            n_checks++;
            if (got !== 16'(2 * i) || to) begin n_fail++; $display("FAIL pre_reset_data i=%0d got %h want %h", i, got, 16'(2 * i)); end
        end
        n_checks++;
        if (mem_addr !== 9'd200) begin n_fail++; $display("FAIL pre_reset_addr got %0d want 200", mem_addr); end
        done_before = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 6;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en got %b want 0", mem_rd_en); end
        if (mem_addr !== 9'd0)  begin n_fail++; $display("FAIL midrst_addr got %0d want 0", mem_addr); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        if (out_data !== 16'h0) begin n_fail++; $display("FAIL midrst_out_data got %h want 0000", out_data); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (done_cnt != done_before) begin n_fail++; $display("FAIL midrst_done got %0d pulses want 0", done_cnt - done_before); end
        mem[0] = 16'h1234;
        pulse_start();
        xfer(16'h0042, 0, 0, 1'b0, got, rd, addr, lat, hb, to);
        n_checks += 2;
        if (got !== 16'h0042 || to) begin n_fail++; $display("FAIL restart_unprimed got %h want 0042", got); end
        if (addr !== 9'd0 || rd != 1) begin n_fail++; $display("FAIL restart_addr got %0d want 0", addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (overlap_cycles != 0) begin n_fail++; $display("FAIL ready_valid_overlap got %0d cycles want 0", overlap_cycles); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_overlap();
        test_saturation_backpressure();
        test_gaps_start();
        test_reset_midframe();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/overlap_reader.md
# overlap_reader

Read-side companion of the overlap storage in the IMDCT overlap-add stage. For every frame it fetches the stored half-window of the previous frame sample by sample through a synchronous read port, adds each sample to the matching sample of the current frame's first half arriving from the IMDCT stream, and emits the saturated sum over a valid/ready output interface. It sits between the overlap storage and the PCM output path; the storage write side is untouched.

## Interface
- halfWindowSize, 512: samples per half-window; must be a power of two ≥ 2.
- wordLength, 16: sample width, two's complement.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last sample is handed off.
- mem_rd_en  out  1  read strobe to the overlap storage.
- mem_addr  out  log2(halfWindowSize)  read address.
- mem_data  in  wordLength  stored sample; valid the cycle after mem_rd_en.
- in_valid  in  1  current-frame sample available.
- in_data  in  wordLength  current-frame sample.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data holds a result.
- out_data  out  wordLength  overlap-added sample.
- out_ready  in  1  downstream accepts out_data.

## Operation
- FSM states: IDLE, FETCH, LATCH, ACCEPT, OUT.
- IDLE: all strobes low; start=1 → FETCH, index i cleared to 0.
- FETCH: mem_rd_en=1, mem_addr=i, held for exactly one cycle → LATCH.
- LATCH: mem_data is registered into prev; if the primed flag is 0, prev is loaded with 0 instead → ACCEPT.
- ACCEPT: in_ready=1; on in_valid, sum=sat(prev+in_data) is registered → OUT. Waits indefinitely while in_valid=0.
- OUT: out_valid=1, out_data stable; on out_ready, if i==halfWindowSize-1 → done=1, primed set to 1, go to IDLE; otherwise i+1 → FETCH.
- Saturation: the full-precision sum is wordLength+1 bits; values above 2^(wordLength-1)-1 clamp to that maximum, values below -2^(wordLength-1) clamp to that minimum.
- The primed flag is 0 after rst. The first frame after reset therefore passes in_data through unchanged, even though mem_rd_en is still issued.
- start while busy: ignored, with no effect on state or index.
- rst at any point, including mid-frame: state IDLE, i=0, primed=0, prev=0, sum=0. A partially emitted frame is abandoned with no done.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, in_ready=0, out_valid=0, out_data=0.
- start sampled in cycle 0 → FETCH in cycle 1 (busy=1) → LATCH in cycle 2 → ACCEPT in cycle 3.
- in_valid in cycle 3 → out_valid in cycle 4.
- Minimum cost is 4 cycles per sample, so a full frame takes at least 4·halfWindowSize cycles from start to done.
- done is asserted in the cycle after the final out_valid&out_ready handshake; busy falls in that same cycle.
- in_ready and out_valid are never high in the same cycle.
- out_data does not change while out_valid=1 and out_ready=0.
- mem_addr holds its last value outside FETCH.

## Structure
- Shared package overlap_pkg:
  - default halfWindowSize and wordLength constants;
  - the FSM state enum;
  - a saturating-add function, parameterised by width, which the write side will reuse.
- No sub-module; a single module holding the FSM, index counter, prev and sum registers, and primed flag.

## Test plan
- Reset, then start; memory returns 0x7FFF everywhere; in_data = 0..511 → outputs equal in_data (unprimed); done after the 512th handshake.
- Second frame: memory[i]=i, in_data[i]=2i → out[i]=3i for all i; mem_addr sequence 0..511, one mem_rd_en per sample.
- Saturation: prev=0x7000, in=0x7000 → 0x7FFF; prev=0x8000, in=0xFFFF → 0x8000; prev=0x0001, in=0xFFFF → 0x0000.
- Backpressure: out_ready low for 10 cycles at i=5 → out_valid held and out_data stable; no FETCH for i=6 until the handshake completes.
- Random in_valid gaps plus a start pulse mid-frame → the start is ignored and all outputs still match the model.
- rst asserted at i=200 → outputs take their reset values next cycle, no done; a new start restarts at mem_addr 0 and passes data through unprimed.
